peri_bus_arbiter: RTL and testbench
===================================

# peri_bus_arbiter

Two-master arbiter for the TRSQ8 8-bit peripheral bus (RAM 0x00–0x7F, SPI 0x80–0x83, GPIO 0x84–0x87, IIC 0x90–0x93). It lets the CPU (master 0) and a second bus master (master 1, e.g. a DMA or boot loader) share the single addr/data/wr_en/rd_en path that feeds the address decoder. Arbitration is round-robin with a bounded hold time and an optional lock. Read data is returned registered to the owning master.

## Interface
- MAX_HOLD, 16: maximum consecutive granted cycles before a forced handover when the other master waits and lock is low; legal range 1–255.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  bus request
- m0_lock, m1_lock  in  1  suppress forced handover while owner
- m0_addr, m1_addr  in  8  access address
- m0_wdata, m1_wdata  in  8  write data
- m0_wr_en, m1_wr_en  in  1  write strobe, one access per cycle
- m0_rd_en, m1_rd_en  in  1  read strobe
- m0_gnt, m1_gnt  out  1  registered grant; at most one high
- m0_rdata, m1_rdata  out  8  registered read data
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse, rdata valid
- peri_addr  out  8  to decoder
- peri_dout  out  8  write data to decoder
- peri_wr_en, peri_rd_en  out  1  strobes to decoder
- peri_din  in  8  combinational read data from decoder
- err_drop  out  1  sticky: strobe seen from a non-granted master

## Operation
- State machine: IDLE, OWN0, OWN1. m0_gnt = (state==OWN0), m1_gnt = (state==OWN1).
- IDLE: if exactly one req is high, go to that owner. If both are high, go to the master selected by the round-robin pointer `rr`; `rr` resets to favour m0.
- OWNx, req_x low:
  - other req high → OWNother.
  - otherwise → IDLE.
- OWNx, req_x high:
  - stay, unless hold_cnt == MAX_HOLD−1 and other req is high and lock_x is low → OWNother.
- On every grant change: hold_cnt clears to 0 and `rr` points to the master that just lost the grant. Otherwise, while owning, hold_cnt increments and saturates at MAX_HOLD−1.
- Lock only blocks forced handover. A voluntary release (req low) always hands over.
- Slave-side mux (combinational, from registered state):
  - peri_addr/peri_dout follow the owner's addr/wdata.
  - peri_wr_en/peri_rd_en = owner strobe & ~reset.
  - In IDLE: all 0.
- Read return: when peri_rd_en is high, peri_din is registered into the owner's rdata and that owner's rvalid pulses on the next cycle. The other master's rdata holds its old value.
- A strobe from a non-owner, or any strobe in IDLE, is dropped (never forwarded or queued) and sets err_drop. err_drop clears only on reset.
- Simultaneous wr_en and rd_en from the owner: both are forwarded unchanged. Decoder semantics apply; the arbiter does not resolve the conflict.

## Timing
- Reset values: state IDLE, all gnt 0, all rvalid 0, all rdata 0x00, peri_* 0, hold_cnt 0, rr=m0, err_drop 0.
- Request → grant: 1 cycle from IDLE (req sampled at edge N, gnt high after edge N).
- Handover: no dead cycle. The old owner's strobe in its last gnt cycle is forwarded; the new owner may strobe in its first gnt cycle.
- Access latency: write and read strobes reach the decoder in the same cycle. rdata/rvalid arrive 1 cycle later, even if the grant has since moved.
- Forced handover: with both masters requesting continuously and lock low, each tenure is exactly MAX_HOLD cycles.
- Reset asserted mid-tenure:
  - peri strobes are gated to 0 in that cycle.
  - Outputs take reset values after the edge.
  - A pending rvalid is discarded.

## Structure
- Package trsq8_bus_pkg holds:
  - the arb state enum (IDLE/OWN0/OWN1);
  - bus width constants (ADDR_W=8, DATA_W=8);
  - address-map base/limit constants for RAM, SPI, GPIO and IIC, used by the decoder and by the bench.
- One sub-module, peri_arb_rr: the round-robin pick, with inputs req[1:0] and rr and output winner. All other logic lives in the top module.

## Test plan
- Reset, then m0_req=1 only → m0_gnt=1 after 1 cycle. m0 write 0x5A to 0x10 → peri_wr_en=1, peri_addr=0x10, peri_dout=0x5A in the same cycle.
- Both req rise together after reset → m0 granted first. m0 drops req → m1_gnt next cycle with no gap. Both re-request → m1 keeps the grant until forced handover, then m0.
- MAX_HOLD=4, both req held, locks low → gnt alternates every 4 cycles. Set m1_lock during m1 tenure → m1 holds indefinitely until m1_req drops.
- m1 owns and reads 0x84 with peri_din=0xC3 → m1_rdata=0xC3 and m1_rvalid pulse next cycle. m0_rvalid stays 0 and m0_rdata is unchanged.
- m0 asserts wr_en while m1 owns → no peri_wr_en, err_drop=1 and stays set until reset.
- Assert reset in a cycle where the owner strobes rd_en → peri_rd_en=0 that cycle. Afterwards gnt=0, rvalid=0, rdata=0x00, err_drop=0.

Source files
------------

// File: rtl/trsq8_bus_pkg.sv
// Shared definitions for the TRSQ8 8-bit peripheral bus.
//   arb_state_t : bus arbiter ownership state
//   ADDR_W/DATA_W : bus widths
//   *_BASE/*_LIMIT : inclusive address windows seen by the decoder
package trsq8_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] RAM_BASE   = 8'h00;
  localparam logic [ADDR_W-1:0] RAM_LIMIT  = 8'h7F;
  localparam logic [ADDR_W-1:0] SPI_BASE   = 8'h80;
  localparam logic [ADDR_W-1:0] SPI_LIMIT  = 8'h83;
  localparam logic [ADDR_W-1:0] GPIO_BASE  = 8'h84;
  localparam logic [ADDR_W-1:0] GPIO_LIMIT = 8'h87;
  localparam logic [ADDR_W-1:0] IIC_BASE   = 8'h90;
  localparam logic [ADDR_W-1:0] IIC_LIMIT  = 8'h93;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/peri_bus_arbiter_if.sv
// One master's connection to the peripheral bus arbiter.
//   master modport : bus master side (drives req/lock/addr/wdata/strobes)
//   slave modport  : arbiter side (returns gnt, rdata, rvalid)
interface peri_bus_arbiter_if;
  import trsq8_bus_pkg::*;

  logic              req;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr_en;
  logic              rd_en;
  logic              gnt;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output req, lock, addr, wdata, wr_en, rd_en,
                  input  gnt, rdata, rvalid);
  modport slave  (input  req, lock, addr, wdata, wr_en, rd_en,
                  output gnt, rdata, rvalid);
endinterface

// File: rtl/peri_arb_rr.sv
// Round-robin pick between two requesters.
//   req[1:0] : requests, bit i = master i
//   rr       : master favoured when both request
//   winner   : selected master (only meaningful when |req)
module peri_arb_rr (
  input  logic [1:0] req,
  input  logic       rr,
  output logic       winner
);
  always_comb begin
    unique case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = rr;
      default: winner = 1'b0;
    endcase
  end
endmodule

// File: rtl/peri_bus_arbiter.sv
// Two-master arbiter for the TRSQ8 peripheral bus.
//   clk, reset       : clock, synchronous active-high reset
//   m0, m1           : master ports (req/lock/addr/wdata/wr_en/rd_en in,
//                      gnt/rdata/rvalid out)
//   peri_addr/dout   : owner's address/write data to the decoder
//   peri_wr_en/rd_en : owner's strobes to the decoder, gated by reset
//   peri_din         : combinational read data from the decoder
//   err_drop         : sticky flag, strobe seen from a non-owner
// Ownership rotates on release or after MAX_HOLD granted cycles when the
// other master waits; an owner's lock only suppresses the forced rotation.
module peri_bus_arbiter
  import trsq8_bus_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  peri_bus_arbiter_if.slave m0,
  peri_bus_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] peri_addr,
  output logic [DATA_W-1:0] peri_dout,
  output logic              peri_wr_en,
  output logic              peri_rd_en,
  input  logic [DATA_W-1:0] peri_din,
  output logic              err_drop
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t             state;
  logic [7:0]             hold_cnt;
  logic                   rr;
  logic                   winner;
  logic [1:0]             req, lock, wr, rd, own;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic [1:0]             rvalid_q;
  logic                   hold_done;

  assign req  = {m1.req,   m0.req};
  assign lock = {m1.lock,  m0.lock};
  assign wr   = {m1.wr_en, m0.wr_en};
  assign rd   = {m1.rd_en, m0.rd_en};
  assign own  = {state == OWN1, state == OWN0};

  assign hold_done = (hold_cnt == HOLD_LAST);

  assign m0.gnt    = own[0];
  assign m1.gnt    = own[1];
  assign m0.rdata  = rdata_q[0];
  assign m1.rdata  = rdata_q[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];

  peri_arb_rr u_rr (.req(req), .rr(rr), .winner(winner));

  // Ownership FSM. Leaving OWNx always goes to the other master if it is
  // requesting, so a handover never costs an idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rr       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (|req) state <= winner ? OWN1 : OWN0;
        end
        OWN0: begin
          if (!req[0] || (hold_done && req[1] && !lock[0])) begin
            state    <= req[1] ? OWN1 : IDLE;
            hold_cnt <= '0;
            rr       <= 1'b0;
          end else if (!hold_done) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        OWN1: begin
          if (!req[1] || (hold_done && req[0] && !lock[1])) begin
            state    <= req[0] ? OWN0 : IDLE;
            hold_cnt <= '0;
            rr       <= 1'b1;
          end else if (!hold_done) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave-side mux straight from the registered owner; strobes are
  // gated by reset so an access in the reset cycle never reaches a device.
  always_comb begin
    peri_addr  = '0;
    peri_dout  = '0;
    peri_wr_en = 1'b0;
    peri_rd_en = 1'b0;
    unique case (state)
      OWN0: begin
        peri_addr  = m0.addr;
        peri_dout  = m0.wdata;
        peri_wr_en = m0.wr_en & ~reset;
        peri_rd_en = m0.rd_en & ~reset;
      end
      OWN1: begin
        peri_addr  = m1.addr;
        peri_dout  = m1.wdata;
        peri_wr_en = m1.wr_en & ~reset;
        peri_rd_en = m1.rd_en & ~reset;
      end
      default: ;
    endcase
  end

  // Read return is tagged with the owner at strobe time, so it still lands
  // at the right master if the grant moves on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
      err_drop <= 1'b0;
    end else begin
      rvalid_q <= own & {2{peri_rd_en}};
      for (int i = 0; i < 2; i++)
        if (peri_rd_en && own[i]) rdata_q[i] <= peri_din;
      if (|((wr | rd) & ~own)) err_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_peri_bus_arbiter.sv
module tb_peri_bus_arbiter;
  import trsq8_bus_pkg::*;

  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] peri_addr;
  logic [DATA_W-1:0] peri_dout;
  logic              peri_wr_en, peri_rd_en;
  logic [DATA_W-1:0] peri_din;
  logic              err_drop;

  peri_bus_arbiter_if m0_if ();
  peri_bus_arbiter_if m1_if ();

  peri_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
    .peri_addr(peri_addr), .peri_dout(peri_dout),
    .peri_wr_en(peri_wr_en), .peri_rd_en(peri_rd_en),
    .peri_din(peri_din), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // scoreboard of expected read returns
  typedef struct {
    logic       who;
    logic [7:0] data;
    int         cyc;
  } rd_exp_t;
  rd_exp_t sb[$];
  rd_exp_t e;

  always @(negedge clk) begin
    if (m0_if.rvalid === 1'b1 || m1_if.rvalid === 1'b1) begin
      chk("rv_excl", {31'b0, m0_if.rvalid & m1_if.rvalid}, 0);
      if (sb.size() == 0) begin
        chk("rv_spurious", {31'b0, m0_if.rvalid | m1_if.rvalid}, 0);
      end else begin
        e = sb.pop_front();
        chk("rv_who", {31'b0, m1_if.rvalid}, {31'b0, e.who});
        chk("rv_data", m1_if.rvalid ? m1_if.rdata : m0_if.rdata, e.data);
        chk("rv_cyc", cyc_n, e.cyc + 1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    chk({tag, "_m0gnt"}, m0_if.gnt, g0);
    chk({tag, "_m1gnt"}, m1_if.gnt, g1);
  endtask

  // check that master o holds the grant for n consecutive cycles
  task automatic own_for(input int o, input int n);
    for (int k = 0; k < n; k++) begin
      #2;
      chk_gnt($sformatf("tenure_o%0d_k%0d", o, k), o == 0, o == 1);
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] wa[3];
  logic [7:0] wd[3];

  initial begin
    reset = 1'b1;
    peri_din = '0;
    {m0_if.req, m0_if.lock, m0_if.wr_en, m0_if.rd_en} = '0;
    {m1_if.req, m1_if.lock, m1_if.wr_en, m1_if.rd_en} = '0;
    m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.addr = '0; m1_if.wdata = '0;
    cyc(); cyc();

    // reset state
    #2;
    chk_gnt("rst", 0, 0);
    chk("rst_m0_rvalid", m0_if.rvalid, 0);
    chk("rst_m1_rvalid", m1_if.rvalid, 0);
    chk("rst_m0_rdata", m0_if.rdata, 0);
    chk("rst_m1_rdata", m1_if.rdata, 0);
    chk("rst_peri", {peri_addr, peri_dout, peri_wr_en, peri_rd_en}, 0);
    chk("rst_err", err_drop, 0);

    // m0 alone: grant one cycle after request, writes forwarded same cycle
    cyc();
    reset = 1'b0;
    m0_if.req = 1'b1;
    #2 chk_gnt("req_pre", 0, 0);
    cyc();
    #2 chk_gnt("req_gnt", 1, 0);
    wa[0] = 8'h10;     wd[0] = 8'h5A;
    wa[1] = SPI_BASE;  wd[1] = 8'hFF;
    wa[2] = IIC_LIMIT; wd[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      m0_if.wr_en = 1'b1; m0_if.addr = wa[i]; m0_if.wdata = wd[i];
      #2;
      chk($sformatf("wr%0d_en", i), peri_wr_en, 1);
      chk($sformatf("wr%0d_rd", i), peri_rd_en, 0);
      chk($sformatf("wr%0d_addr", i), peri_addr, wa[i]);
      chk($sformatf("wr%0d_dout", i), peri_dout, wd[i]);
    end
    cyc();
    m0_if.wr_en = 1'b0; m0_if.rd_en = 1'b1; m0_if.addr = RAM_LIMIT;
    peri_din = 8'h11;
    #2;
    chk("m0rd_en", peri_rd_en, 1);
    chk("m0rd_addr", peri_addr, RAM_LIMIT);
    sb.push_back('{who: 1'b0, data: 8'h11, cyc: cyc_n});
    cyc();
    m0_if.rd_en = 1'b0; m0_if.req = 1'b0;
    #2;
    chk("m0rd_data", m0_if.rdata, 8'h11);
    chk("m0rd_m1hold", m1_if.rdata, 0);
    chk("m0rd_m1rv", m1_if.rvalid, 0);
    cyc();
    #2 chk_gnt("release_idle", 0, 0);

    // both request together: m0 first, voluntary release to m1 with no gap
    cyc();
    m0_if.req = 1'b1; m1_if.req = 1'b1;
    cyc();
    #2 chk_gnt("rr_first", 1, 0);
    m0_if.req = 1'b0;
    cyc();
    m0_if.req = 1'b1;
    own_for(1, MAX_HOLD);
    own_for(0, MAX_HOLD - 1);
    // last cycle of m0 tenure: its strobe still goes out
    m0_if.wr_en = 1'b1; m0_if.addr = 8'h20; m0_if.wdata = 8'hA5;
    #2;
    chk_gnt("ho_last", 1, 0);
    chk("ho_last_wr", peri_wr_en, 1);
    chk("ho_last_addr", peri_addr, 8'h20);
    chk("ho_last_dout", peri_dout, 8'hA5);
    cyc();
    // first cycle of m1 tenure: its strobe goes out immediately
    m0_if.wr_en = 1'b0;
    m1_if.wr_en = 1'b1; m1_if.addr = 8'h21; m1_if.wdata = 8'h3C;
    #2;
    chk_gnt("ho_first", 0, 1);
    chk("ho_first_wr", peri_wr_en, 1);
    chk("ho_first_addr", peri_addr, 8'h21);
    chk("ho_first_dout", peri_dout, 8'h3C);
    chk("ho_err", err_drop, 0);
    cyc();
    m1_if.wr_en = 1'b0;
    own_for(1, MAX_HOLD - 1);
    own_for(0, MAX_HOLD);

    // lock holds m1 past MAX_HOLD; dropping req still hands over
    m1_if.lock = 1'b1;
    own_for(1, 3 * MAX_HOLD);
    m1_if.req = 1'b0;
    #2 chk_gnt("lock_last", 0, 1);
    cyc();
    m1_if.lock = 1'b0;
    #2 chk_gnt("lock_release", 1, 0);

    // m1 owns and reads GPIO; m0 side untouched
    m0_if.req = 1'b0; m1_if.req = 1'b1;
    cyc();
    #2 chk_gnt("m1_own", 0, 1);
    m1_if.rd_en = 1'b1; m1_if.addr = GPIO_BASE; peri_din = 8'hC3;
    #2;
    chk("m1rd_en", peri_rd_en, 1);
    chk("m1rd_wr", peri_wr_en, 0);
    chk("m1rd_addr", peri_addr, GPIO_BASE);
    sb.push_back('{who: 1'b1, data: 8'hC3, cyc: cyc_n});
    cyc();
    m1_if.rd_en = 1'b0; peri_din = 8'h00;
    #2;
    chk("m1rd_m0rv", m0_if.rvalid, 0);
    chk("m1rd_m0data", m0_if.rdata, 8'h11);
    chk("m1rd_m1data", m1_if.rdata, 8'hC3);

    // non-owner strobe is dropped and flagged
    cyc();
    m0_if.wr_en = 1'b1; m0_if.addr = 8'h10; m0_if.wdata = 8'h99;
    #2;
    chk("drop_wr", peri_wr_en, 0);
    chk("drop_err_pre", err_drop, 0);
    cyc();
    m0_if.wr_en = 1'b0;
    #2 chk("drop_err_set", err_drop, 1);
    cyc(); cyc(); cyc();
    #2 chk("drop_err_sticky", err_drop, 1);

    // reset while the owner reads: strobe gated, read discarded
    cyc();
    m1_if.rd_en = 1'b1; m1_if.addr = SPI_LIMIT; peri_din = 8'h77;
    reset = 1'b1;
    #2 chk("rst_gate_rd", peri_rd_en, 0);
    cyc();
    reset = 1'b0;
    m1_if.rd_en = 1'b0; m1_if.req = 1'b0;
    #2;
    chk_gnt("rst2", 0, 0);
    chk("rst2_m0_rvalid", m0_if.rvalid, 0);
    chk("rst2_m1_rvalid", m1_if.rvalid, 0);
    chk("rst2_m0_rdata", m0_if.rdata, 0);
    chk("rst2_m1_rdata", m1_if.rdata, 0);
    chk("rst2_err", err_drop, 0);
    chk("rst2_peri_rd", peri_rd_en, 0);
    cyc(); cyc();
    #2 chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
